mem_handler: RTL and testbench
==============================

Name: mem_handler

Overview:
- Multi-cycle memory sequencer between the RISC-V core and the shared instruction/data `ram`.
- Each instruction is handled in fixed phases: fetch the instruction, sample the core's load/store request, perform the data access, then release the core.
- Drives the ram's `read_enable`, `write_enable`, `address_IM`, `address_DM` and `data_in`. Consumes `instr_out` and `data_out`.
- Produces the fetched instruction, extended load data and `pc_enable`, which tells the core to advance the PC.

Parameters:
- ADDR_W, 5: ram word-address width. Byte address bits [ADDR_W+1:2] select the word; higher bits are ignored, so addresses wrap.
- RD_LAT, 1: ram read latency in cycles, legal range 1..3. Data is valid RD_LAT cycles after the edge that samples `read_enable`.

Ports:
- clk  in  1  system clock
- nRst  in  1  reset, asynchronous, active-low
- i_pc  in  32  byte address of the current instruction; held stable until o_pc_enable
- i_mem_read  in  1  load request, sampled at the end of EXEC
- i_mem_write  in  1  store request, sampled at the end of EXEC
- i_funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use only 000/001/010)
- i_addr  in  32  load/store byte address
- i_wdata  in  32  store data, LSB-aligned
- o_instr  out  32  fetched instruction, held until the next fetch captures
- o_rdata  out  32  extended load data, held until the next load captures
- o_pc_enable  out  1  one-cycle pulse in DONE
- o_fault  out  1  one-cycle pulse in DONE when the request was illegal
- read_enable  out  1  to ram
- write_enable  out  1  to ram
- address_IM  out  ADDR_W  to ram, equals i_pc[ADDR_W+1:2] in FETCH
- address_DM  out  ADDR_W  to ram, equals latched addr[ADDR_W+1:2]
- data_in  out  32  to ram, store word
- instr_out  in  32  from ram
- data_out  in  32  from ram

Behaviour:
- Reset (nRst=0, asynchronous):
  - state = FETCH; all outputs = 0; latency counter = 0.
  - Reset mid-operation aborts immediately: no partial write is issued and there is no pc_enable.
- States: FETCH, F_WAIT, EXEC, LD_REQ, LD_WAIT, RMW_REQ, RMW_WAIT, ST_WR, DONE.
- FETCH: read_enable=1, address_IM=i_pc word. Go to F_WAIT.
- F_WAIT: read_enable=0. Stay RD_LAT cycles. On the last cycle, capture instr_out into o_instr, then go to EXEC.
- EXEC (1 cycle): the core decodes o_instr. At the end of the cycle, latch i_mem_read, i_mem_write, i_funct3, i_addr and i_wdata.
- EXEC fault conditions (go to DONE with fault set):
  - both i_mem_read and i_mem_write high
  - i_funct3 illegal for the access type
  - H/HU access with addr[0]=1
  - W access with addr[1:0]≠0
- EXEC branches (no fault):
  - load → LD_REQ
  - SW → ST_WR
  - SB/SH → RMW_REQ
  - no request → DONE
- LD_REQ: read_enable=1, address_DM valid. Go to LD_WAIT.
- LD_WAIT: wait RD_LAT cycles. On the last cycle, select the lane from data_out (little-endian, lane = addr[1:0]), sign- or zero-extend per funct3 into o_rdata, then go to DONE.
- RMW_REQ / RMW_WAIT: same read sequence as a load. On the last cycle, merge store bytes into the read word and register the result as the write word. Go to ST_WR.
- ST_WR (1 cycle): write_enable=1, address_DM valid, data_in = write word (i_wdata for SW, merged word for SB/SH). Go to DONE.
- DONE (1 cycle): o_pc_enable=1, o_fault=1 if a fault was latched. Go to FETCH; the core updates i_pc on this edge.
- Invariants:
  - read_enable and write_enable are never high in the same cycle.
  - A fault issues no ram access.
  - o_rdata is unchanged on non-loads and on faults.
- Cycle counts at RD_LAT=1: no-mem 4, SW 5, load 6, SB/SH 7.

Test Plan:
- Reset: hold nRst=0 for 3 cycles → all outputs 0. First cycle after release: read_enable=1, address_IM=i_pc[6:2].
- ALU instruction: i_pc=0x08, ram word2=0x00500093, no request → o_instr=0x00500093. o_pc_enable pulses exactly once, 4 cycles after fetch start. write_enable stays 0.
- Loads from word4=0x80FF7F01:
  - LB 0x13 → o_rdata=0xFFFFFF80
  - LBU 0x13 → 0x00000080
  - LH 0x12 → 0xFFFF80FF
  - each takes 6 cycles
- SB 0x05, i_wdata=0x000000AB, word1=0x11223344 → one write_enable cycle with address_DM=1, data_in=0x1122AB44. Total 7 cycles.
- SW 0x06 → no read or write enables; o_fault and o_pc_enable pulse together. SW 0x84 → address_DM=1 (wrap).
- Pull nRst low during RMW_WAIT → write_enable never asserts and no pc_enable. After release the handler restarts at FETCH.

Source files
------------

// File: rtl/mem_handler.sv
// ---------------------------------------------------------------------------
// mem_handler
//
// Multi-cycle memory sequencer that sits between the RISC-V core and the
// shared instruction/data ram. Every instruction goes through the same
// phases: fetch the instruction word, let the core decode it for one cycle
// (EXEC), perform the optional data access, then release the core with a
// one-cycle o_pc_enable pulse.
//
// Sub-word stores are done as read-modify-write: the containing word is read,
// the store lanes are merged in, and the merged word is written back.
//
// Ports
//   clk           system clock
//   nRst          asynchronous active-low reset
//   i_pc          byte address of the current instruction (held until o_pc_enable)
//   i_mem_read    load request, sampled at the end of EXEC
//   i_mem_write   store request, sampled at the end of EXEC
//   i_funct3      access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   i_addr        load/store byte address
//   i_wdata       store data, LSB-aligned
//   o_instr       fetched instruction, held until the next fetch
//   o_rdata       extended load data, held until the next load
//   o_pc_enable   one-cycle pulse in DONE
//   o_fault       one-cycle pulse in DONE when the request was illegal
//   read_enable   ram read strobe
//   write_enable  ram write strobe
//   address_IM    ram instruction word address
//   address_DM    ram data word address
//   data_in       ram write data
//   instr_out     ram instruction read data
//   data_out      ram data read data
// ---------------------------------------------------------------------------
module mem_handler #(
   parameter int ADDR_W = 5,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic [31:0]       i_pc,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [2:0]        i_funct3,
   input  logic [31:0]       i_addr,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_instr,
   output logic [31:0]       o_rdata,
   output logic              o_pc_enable,
   output logic              o_fault,
   output logic              read_enable,
   output logic              write_enable,
   output logic [ADDR_W-1:0] address_IM,
   output logic [ADDR_W-1:0] address_DM,
   output logic [31:0]       data_in,
   input  logic [31:0]       instr_out,
   input  logic [31:0]       data_out
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_F_WAIT,
      S_EXEC,
      S_LD_REQ,
      S_LD_WAIT,
      S_RMW_REQ,
      S_RMW_WAIT,
      S_ST_WR,
      S_DONE
   } state_t;

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   state_t              r_state;
   state_t              w_nextState;
   logic [1:0]          r_latCnt;
   logic                w_latLast;
   logic                w_inWait;

   logic [2:0]          r_funct3;
   logic [ADDR_W+1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [31:0]         r_instr;
   logic [31:0]         r_rdata;
   logic                r_fault;

   logic                w_loadF3Ok;
   logic                w_storeF3Ok;
   logic                w_misaligned;
   logic                w_execFault;

   logic [4:0]          w_laneShift;
   logic [31:0]         w_laneWord;
   logic [31:0]         w_loadData;
   logic [31:0]         w_laneMask;
   logic [31:0]         w_mergedWord;

   logic                w_unused;

   // Address bits above the ram window wrap, and the byte-offset bits of the
   // PC carry no information for a word-addressed ram.
   assign w_unused = &{1'b0, i_pc[31:ADDR_W+2], i_pc[1:0], i_addr[31:ADDR_W+2]};

   assign w_latLast = (r_latCnt == LAT_LAST);
   assign w_inWait  = (r_state == S_F_WAIT) || (r_state == S_LD_WAIT) || (r_state == S_RMW_WAIT);

   // Request legality, evaluated on the live core inputs during EXEC so the
   // branch out of EXEC can be taken on the same edge that latches them.
   always_comb begin
      w_loadF3Ok   = 1'b0;
      w_misaligned = 1'b0;
      case (i_funct3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_loadF3Ok = 1'b1;
         default:                                w_loadF3Ok = 1'b0;
      endcase
      w_storeF3Ok = ~i_funct3[2] & (i_funct3[1:0] != 2'b11);
      case (i_funct3[1:0])
         2'b01:   w_misaligned = i_addr[0];
         2'b10:   w_misaligned = (i_addr[1:0] != 2'b00);
         default: w_misaligned = 1'b0;
      endcase
      w_execFault = (i_mem_read & i_mem_write)
                  | (i_mem_read & ~w_loadF3Ok)
                  | (i_mem_write & ~w_storeF3Ok)
                  | ((i_mem_read | i_mem_write) & w_misaligned);
   end

   // Lane selection and extension for loads, and lane merge for sub-word
   // stores. Both work on the little-endian byte offset of the latched address.
   always_comb begin
      w_laneShift = {r_addr[1:0], 3'b000};
      w_laneWord  = data_out >> w_laneShift;
      case (r_funct3)
         3'b000:  w_loadData = {{24{w_laneWord[7]}}, w_laneWord[7:0]};
         3'b001:  w_loadData = {{16{w_laneWord[15]}}, w_laneWord[15:0]};
         3'b100:  w_loadData = {24'h000000, w_laneWord[7:0]};
         3'b101:  w_loadData = {16'h0000, w_laneWord[15:0]};
         default: w_loadData = data_out;
      endcase
      w_laneMask   = (r_funct3[0] ? 32'h0000FFFF : 32'h000000FF) << w_laneShift;
      w_mergedWord = (data_out & ~w_laneMask) | ((r_wdata << w_laneShift) & w_laneMask);
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_FETCH:    w_nextState = S_F_WAIT;
         S_F_WAIT:   if (w_latLast) w_nextState = S_EXEC;
         S_EXEC: begin
            if (w_execFault)
               w_nextState = S_DONE;
            else if (i_mem_read)
               w_nextState = S_LD_REQ;
            else if (i_mem_write)
               w_nextState = (i_funct3[1:0] == 2'b10) ? S_ST_WR : S_RMW_REQ;
            else
               w_nextState = S_DONE;
         end
         S_LD_REQ:   w_nextState = S_LD_WAIT;
         S_LD_WAIT:  if (w_latLast) w_nextState = S_DONE;
         S_RMW_REQ:  w_nextState = S_RMW_WAIT;
         S_RMW_WAIT: if (w_latLast) w_nextState = S_ST_WR;
         S_ST_WR:    w_nextState = S_DONE;
         S_DONE:     w_nextState = S_FETCH;
         default:    w_nextState = S_FETCH;
      endcase
   end

   // The reset state is FETCH, which would otherwise drive a read strobe and
   // the PC address while nRst is still low; gating with nRst keeps every
   // ram-facing strobe quiet for the whole reset window.
   always_comb begin
      read_enable  = 1'b0;
      write_enable = 1'b0;
      address_IM   = '0;
      o_pc_enable  = 1'b0;
      o_fault      = 1'b0;
      if (nRst) begin
         case (r_state)
            S_FETCH: begin
               read_enable = 1'b1;
               address_IM  = i_pc[ADDR_W+1:2];
            end
            S_LD_REQ, S_RMW_REQ: read_enable = 1'b1;
            S_ST_WR:             write_enable = 1'b1;
            S_DONE: begin
               o_pc_enable = 1'b1;
               o_fault     = r_fault;
            end
            default: ;
         endcase
      end
   end

   assign address_DM = r_addr[ADDR_W+1:2];
   assign data_in    = r_wdata;
   assign o_instr    = r_instr;
   assign o_rdata    = r_rdata;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state  <= S_FETCH;
         r_latCnt <= 2'd0;
      end else begin
         r_state  <= w_nextState;
         r_latCnt <= (w_inWait && !w_latLast) ? r_latCnt + 2'd1 : 2'd0;
      end
   end

   // Datapath registers. The write word starts as the raw store data and is
   // replaced by the merged word for sub-word stores before ST_WR.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_funct3 <= 3'd0;
         r_addr   <= '0;
         r_wdata  <= 32'd0;
         r_instr  <= 32'd0;
         r_rdata  <= 32'd0;
         r_fault  <= 1'b0;
      end else begin
         case (r_state)
            S_F_WAIT: if (w_latLast) r_instr <= instr_out;
            S_EXEC: begin
               r_funct3 <= i_funct3;
               r_addr   <= i_addr[ADDR_W+1:0];
               r_wdata  <= i_wdata;
               r_fault  <= w_execFault;
            end
            S_LD_WAIT:  if (w_latLast) r_rdata <= w_loadData;
            S_RMW_WAIT: if (w_latLast) r_wdata <= w_mergedWord;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_handler.sv
// ---------------------------------------------------------------------------
// tb_mem_handler
//
// Drives mem_handler against a behavioural one-cycle-latency ram and a
// reference model that works per instruction: it predicts the fetched word,
// fault flag, load result, ram contents and the cycle count of each
// instruction from the access rules alone.
// ---------------------------------------------------------------------------
module tb_mem_handler;

   localparam int AW = 5;
   localparam int WORDS = 32;

   logic          clk;
   logic          nRst;
   logic [31:0]   pc;
   logic          memRead;
   logic          memWrite;
   logic [2:0]    funct3;
   logic [31:0]   addr;
   logic [31:0]   wdata;
   logic [31:0]   instr;
   logic [31:0]   rdata;
   logic          pcEnable;
   logic          faultOut;
   logic          readEnable;
   logic          writeEnable;
   logic [AW-1:0] addressIM;
   logic [AW-1:0] addressDM;
   logic [31:0]   dataIn;
   logic [31:0]   instrOut;
   logic [31:0]   dataOut;

   logic [31:0]   ramMem [WORDS];
   logic [31:0]   refMem [WORDS];
   logic [31:0]   refRdata;

   logic          pokeEn;
   logic [AW-1:0] pokeAddr;
   logic [31:0]   pokeData;

   int            nTests;
   int            nFail;

   mem_handler #(.ADDR_W(AW), .RD_LAT(1)) dut (
      .clk          (clk),
      .nRst         (nRst),
      .i_pc         (pc),
      .i_mem_read   (memRead),
      .i_mem_write  (memWrite),
      .i_funct3     (funct3),
      .i_addr       (addr),
      .i_wdata      (wdata),
      .o_instr      (instr),
      .o_rdata      (rdata),
      .o_pc_enable  (pcEnable),
      .o_fault      (faultOut),
      .read_enable  (readEnable),
      .write_enable (writeEnable),
      .address_IM   (addressIM),
      .address_DM   (addressDM),
      .data_in      (dataIn),
      .instr_out    (instrOut),
      .data_out     (dataOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ram: registered read of both ports one cycle after the
   // strobe, plus a backdoor write port used only while the DUT is in reset.
   always @(posedge clk) begin
      if (pokeEn)
         ramMem[pokeAddr] <= pokeData;
      else if (writeEnable)
         ramMem[addressDM] <= dataIn;
      if (readEnable) begin
         instrOut <= ramMem[addressIM];
         dataOut  <= ramMem[addressDM];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] pcV, input logic rdV, input logic wrV,
                                input logic [2:0] f3V, input logic [31:0] addrV, input logic [31:0] wdV);
      pc       = pcV;
      memRead  = rdV;
      memWrite = wrV;
      funct3   = f3V;
      addr     = addrV;
      wdata    = wdV;
   endtask

   task automatic pokeWord(input int idx, input logic [31:0] val);
      pokeEn   = 1'b1;
      pokeAddr = AW'(idx);
      pokeData = val;
      refMem[idx] = val;
      @(negedge clk);
      pokeEn = 1'b0;
   endtask

   // ---- reference model ----------------------------------------------------

   function automatic int accSize(input logic [2:0] f3);
      int low;
      low = int'(f3) % 4;
      if (low == 0) return 1;
      if (low == 1) return 2;
      return 4;
   endfunction

   function automatic logic refFault(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
      int v;
      v = int'(f3);
      if (!rd && !wr) return 1'b0;
      if (rd && wr) return 1'b1;
      if (rd && !(v == 0 || v == 1 || v == 2 || v == 4 || v == 5)) return 1'b1;
      if (wr && !(v == 0 || v == 1 || v == 2)) return 1'b1;
      return (a % accSize(f3)) != 0;
   endfunction

   function automatic logic [31:0] byteOf(input logic [31:0] w, input int k);
      return (w >> (8 * k)) % 256;
   endfunction

   function automatic logic [31:0] refLoad(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
      int idx;
      logic [31:0] v;
      idx = int'(a % 4);
      if (accSize(f3) == 4) return w;
      if (accSize(f3) == 1) begin
         v = byteOf(w, idx);
         if (f3 < 4 && v >= 128) v = v + 32'hFFFFFF00;
      end else begin
         v = byteOf(w, idx) + 256 * byteOf(w, idx + 1);
         if (f3 < 4 && v >= 32768) v = v + 32'hFFFF0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] refStore(input logic [31:0] old, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] wd);
      int idx;
      logic [31:0] res;
      idx = int'(a % 4);
      res = old;
      for (int k = 0; k < accSize(f3); k++) begin
         res = res - (byteOf(old, idx + k) << (8 * (idx + k)))
                   + (byteOf(wd, k) << (8 * (idx + k)));
      end
      return res;
   endfunction

   // Runs one complete instruction starting at a FETCH cycle (called on a
   // falling edge) and returns on the falling edge that begins the next FETCH.
   task automatic runInstr(input logic [31:0] pcV, input logic rdV, input logic wrV,
                           input logic [2:0] f3V, input logic [31:0] addrV, input logic [31:0] wdV);
      logic        expFault;
      int          pcIdx;
      int          dIdx;
      int          expCycles;
      int          expReads;
      int          expWrites;
      logic [31:0] expWord;
      int          cycles;
      int          reads;
      int          writes;
      int          faults;
      int          overlap;
      logic [31:0] wrAddr;
      logic [31:0] wrData;
      bit          seenDone;

      expFault = refFault(rdV, wrV, f3V, addrV);
      pcIdx    = int'((pcV / 4) % WORDS);
      dIdx     = int'((addrV / 4) % WORDS);
      expWord  = refMem[dIdx];
      expReads = 1;
      expWrites = 0;
      if (expFault || (!rdV && !wrV)) begin
         expCycles = 4;
      end else if (rdV) begin
         expCycles = 6;
         expReads  = 2;
      end else if (accSize(f3V) == 4) begin
         expCycles = 5;
         expWrites = 1;
         expWord   = wdV;
      end else begin
         expCycles = 7;
         expReads  = 2;
         expWrites = 1;
         expWord   = refStore(refMem[dIdx], f3V, addrV, wdV);
      end

      applyStimulus(pcV, rdV, wrV, f3V, addrV, wdV);
      #1;
      checkOutput("fetchRe", 32'(readEnable), 32'd1);
      checkOutput("fetchAddr", 32'(addressIM), 32'(pcIdx));

      cycles = 0; reads = 0; writes = 0; faults = 0; overlap = 0;
      wrAddr = 0; wrData = 0; seenDone = 0;
      while (!seenDone && cycles < 20) begin
         cycles++;
         if (readEnable) reads++;
         if (writeEnable) begin
            writes++;
            wrAddr = 32'(addressDM);
            wrData = dataIn;
         end
         if (readEnable && writeEnable) overlap++;
         if (faultOut) faults++;
         if (pcEnable) seenDone = 1;
         else begin
            @(negedge clk);
            #1;
         end
      end

      checkOutput("doneSeen", 32'(seenDone), 32'd1);
      checkOutput("cycles", 32'(cycles), 32'(expCycles));
      checkOutput("fault", 32'(faults), 32'(expFault));
      checkOutput("reads", 32'(reads), 32'(expReads));
      checkOutput("writes", 32'(writes), 32'(expWrites));
      checkOutput("rwOverlap", 32'(overlap), 32'd0);
      checkOutput("instr", instr, refMem[pcIdx]);
      if (expWrites == 1) begin
         refMem[dIdx] = expWord;
         checkOutput("wrAddr", wrAddr, 32'(dIdx));
         checkOutput("wrData", wrData, expWord);
         checkOutput("ramWord", ramMem[dIdx], expWord);
      end
      if (rdV && !expFault) refRdata = refLoad(refMem[dIdx], f3V, addrV);
      checkOutput("rdata", rdata, refRdata);

      @(negedge clk);
   endtask

   // ---- directed and random sequence --------------------------------------

   initial begin
      logic [31:0] rAddr;
      logic [2:0]  rF3;
      int          kind;

      nTests   = 0;
      nFail    = 0;
      refRdata = 32'd0;
      pokeEn   = 1'b0;
      pokeAddr = '0;
      pokeData = 32'd0;
      nRst     = 1'b0;
      applyStimulus(32'h8, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

      // Preload the ram while the DUT is held in reset.
      @(negedge clk);
      for (int i = 0; i < WORDS; i++) pokeWord(i, $urandom);
      pokeWord(1, 32'h11223344);
      pokeWord(2, 32'h00500093);
      pokeWord(4, 32'h80FF7F01);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rstRe", 32'(readEnable), 32'd0);
      checkOutput("rstWe", 32'(writeEnable), 32'd0);
      checkOutput("rstAddrIM", 32'(addressIM), 32'd0);
      checkOutput("rstAddrDM", 32'(addressDM), 32'd0);
      checkOutput("rstDataIn", dataIn, 32'd0);
      checkOutput("rstInstr", instr, 32'd0);
      checkOutput("rstRdata", rdata, 32'd0);
      checkOutput("rstPcEn", 32'(pcEnable), 32'd0);
      checkOutput("rstFault", 32'(faultOut), 32'd0);

      @(negedge clk);
      nRst = 1'b1;

      runInstr(32'h08, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      checkOutput("aluInstr", instr, 32'h00500093);
      runInstr(32'h0C, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
      checkOutput("lb", rdata, 32'hFFFFFF80);
      runInstr(32'h10, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
      checkOutput("lbu", rdata, 32'h00000080);
      runInstr(32'h14, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
      checkOutput("lh", rdata, 32'hFFFF80FF);
      runInstr(32'h18, 1'b0, 1'b1, 3'b000, 32'h05, 32'h000000AB);
      checkOutput("sbWord", ramMem[1], 32'h1122AB44);
      runInstr(32'h1C, 1'b0, 1'b1, 3'b010, 32'h06, 32'hDEADBEEF);
      runInstr(32'h20, 1'b0, 1'b1, 3'b010, 32'h84, 32'hCAFEF00D);
      checkOutput("swWrap", ramMem[1], 32'hCAFEF00D);

      for (int n = 0; n < 40; n++) begin
         kind  = $urandom_range(0, 3);
         rF3   = 3'($urandom_range(0, 7));
         rAddr = $urandom;
         if ($urandom_range(0, 1) == 1) rAddr[1:0] = 2'b00;
         runInstr($urandom & 32'hFFFFFFFC, kind == 1 || kind == 3, kind == 2 || kind == 3,
                  rF3, rAddr, $urandom);
      end

      // Abort a sub-word store while it waits for its read data.
      applyStimulus(32'h24, 1'b0, 1'b1, 3'b000, 32'h09, 32'h000000CD);
      #1;
      repeat (4) begin
         @(negedge clk);
         #1;
      end
      checkOutput("rmwWaitRe", 32'(readEnable), 32'd0);
      nRst = 1'b0;
      #1;
      checkOutput("abortWe", 32'(writeEnable), 32'd0);
      checkOutput("abortPcEn", 32'(pcEnable), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checkOutput("abortHoldWe", 32'(writeEnable), 32'd0);
         checkOutput("abortHoldPcEn", 32'(pcEnable), 32'd0);
      end
      checkOutput("abortRam", ramMem[2], refMem[2]);
      refRdata = 32'd0;
      @(negedge clk);
      nRst = 1'b1;
      runInstr(32'h08, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      checkOutput("restartLw", rdata, 32'h80FF7F01);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
